// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: access-size codes, control-bus bit positions
// and the memory-access stage state encoding.
package pipeline_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int ST_BIT  = 0;
  localparam int LD_BIT  = 1;
  localparam int SZ_LSB  = 2;
  localparam int UNS_BIT = 4;

  typedef enum logic {
    IDLE,
    ACCESS
  } ma_state_t;

endpackage

// File: rtl/ma_lane_align.sv
// Lane formatting for data memory: store replication, byte enables,
// load extraction with sign/zero extension, and the alignment check.
module ma_lane_align
  import pipeline_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [OFFW-1:0] offset,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [XLEN-1:0] op2,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [NB-1:0]   be,
  output logic [XLEN-1:0] ld_data,
  output logic            misalign
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    wdata    = '0;
    be       = '0;
    mask     = '0;
    sign     = 1'b0;
    misalign = 1'b0;
    shifted  = rdata >> {offset, 3'b000};
    unique case (size)
      SZ_B: begin
        wdata = {NB{op2[7:0]}};
        be    = NB'(1) << offset;
        mask  = XLEN'(8'hFF);
        sign  = shifted[7];
      end
      SZ_H: begin
        wdata    = {(NB/2){op2[15:0]}};
        be       = NB'(2'b11) << offset;
        mask     = XLEN'(16'hFFFF);
        sign     = shifted[15];
        misalign = offset[0];
      end
      SZ_W: begin
        wdata    = {(NB/4){op2[31:0]}};
        be       = NB'(4'hF) << offset;
        mask     = XLEN'(32'hFFFF_FFFF);
        sign     = shifted[31];
        misalign = (offset[1:0] != 2'b00);
      end
      SZ_D: begin
        // A doubleword cannot be accessed on a 32-bit datapath at all.
        wdata    = op2;
        be       = '1;
        mask     = '1;
        misalign = (XLEN == 32) || (offset != '0);
      end
    endcase
    ld_data = (shifted & mask) | ({XLEN{sign & ~uns}} & ~mask);
  end

endmodule

// File: rtl/ma_stage_pipelined.sv
// Registered memory-access stage: accepts one instruction at a time, runs a
// req/ready data-memory access for loads/stores and stalls upstream meanwhile.
module ma_stage_pipelined
  import pipeline_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 22,
  parameter int ST_BIT  = pipeline_pkg::ST_BIT,
  parameter int LD_BIT  = pipeline_pkg::LD_BIT,
  parameter int SZ_LSB  = pipeline_pkg::SZ_LSB,
  parameter int UNS_BIT = pipeline_pkg::UNS_BIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     input_MA_PC,
  input  logic [XLEN-1:0]     input_MA_ALU_Result,
  input  logic [XLEN-1:0]     input_MA_op2,
  input  logic [31:0]         input_MA_IR,
  input  logic [CTRL_W-1:0]   input_MA_controlBus,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_ready,
  output logic                out_valid,
  output logic [XLEN-1:0]     output_MA_PC,
  output logic [XLEN-1:0]     output_MA_ALU_Result,
  output logic [31:0]         output_MA_IR,
  output logic [CTRL_W-1:0]   output_MA_controlBus,
  output logic [XLEN-1:0]     MA_Ld_Result,
  output logic                misalign
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  ma_state_t state, state_next;

  logic [XLEN-1:0]   hold_pc, hold_alu, hold_op2;
  logic [31:0]       hold_ir;
  logic [CTRL_W-1:0] hold_ctrl;

  // Lane logic checks the incoming instruction in IDLE and formats the held one in ACCESS.
  logic [OFFW-1:0] cur_off;
  logic [1:0]      cur_size;
  logic            in_mem, hold_ld;
  logic [XLEN-1:0] ln_wdata, ln_ld;
  logic [NB-1:0]   ln_be;
  logic            ln_mis;

  assign cur_off  = (state == ACCESS) ? hold_alu[OFFW-1:0] : input_MA_ALU_Result[OFFW-1:0];
  assign cur_size = (state == ACCESS) ? hold_ctrl[SZ_LSB +: 2] : input_MA_controlBus[SZ_LSB +: 2];
  assign in_mem   = input_MA_controlBus[ST_BIT] | input_MA_controlBus[LD_BIT];
  assign hold_ld  = hold_ctrl[LD_BIT] & ~hold_ctrl[ST_BIT];

  ma_lane_align #(.XLEN(XLEN)) u_lane (
    .offset   (cur_off),
    .size     (cur_size),
    .uns      (hold_ctrl[UNS_BIT]),
    .op2      (hold_op2),
    .rdata    (mem_rdata),
    .wdata    (ln_wdata),
    .be       (ln_be),
    .ld_data  (ln_ld),
    .misalign (ln_mis)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mem_req    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && in_mem && !ln_mis) state_next = ACCESS;
      end
      ACCESS: begin
        mem_req = 1'b1;
        if (mem_ready) state_next = IDLE;
      end
    endcase
  end

  assign mem_we    = mem_req & hold_ctrl[ST_BIT];
  assign mem_addr  = mem_req ? {hold_alu[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
  assign mem_wdata = mem_req ? ln_wdata : '0;
  assign mem_be    = mem_req ? ln_be : '0;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_pc              <= '0;
      hold_alu             <= '0;
      hold_op2             <= '0;
      hold_ir              <= '0;
      hold_ctrl            <= '0;
      out_valid            <= 1'b0;
      output_MA_PC         <= '0;
      output_MA_ALU_Result <= '0;
      output_MA_IR         <= '0;
      output_MA_controlBus <= '0;
      MA_Ld_Result         <= '0;
      misalign             <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE && in_valid) begin
        if (in_mem && !ln_mis) begin
          hold_pc   <= input_MA_PC;
          hold_alu  <= input_MA_ALU_Result;
          hold_op2  <= input_MA_op2;
          hold_ir   <= input_MA_IR;
          hold_ctrl <= input_MA_controlBus;
        end else begin
          out_valid            <= 1'b1;
          output_MA_PC         <= input_MA_PC;
          output_MA_ALU_Result <= input_MA_ALU_Result;
          output_MA_IR         <= input_MA_IR;
          output_MA_controlBus <= input_MA_controlBus;
          MA_Ld_Result         <= '0;
          misalign             <= in_mem & ln_mis;
        end
      end else if (state == ACCESS && mem_ready) begin
        out_valid            <= 1'b1;
        output_MA_PC         <= hold_pc;
        output_MA_ALU_Result <= hold_alu;
        output_MA_IR         <= hold_ir;
        output_MA_controlBus <= hold_ctrl;
        MA_Ld_Result         <= hold_ld ? ln_ld : '0;
        misalign             <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ma_stage_pipelined.sv
// Self-checking bench for ma_stage_pipelined: vector table applied through a
// scoreboard, plus reset-during-access and back-to-back sequences.
module tb_ma_stage_pipelined;

  localparam logic [21:0] C_ALU = 22'h0002A0;
  localparam logic [21:0] C_SB  = 22'h01;
  localparam logic [21:0] C_SH  = 22'h05;
  localparam logic [21:0] C_SW  = 22'h09;
  localparam logic [21:0] C_LB  = 22'h02;
  localparam logic [21:0] C_LBU = 22'h12;
  localparam logic [21:0] C_LH  = 22'h06;
  localparam logic [21:0] C_LHU = 22'h16;
  localparam logic [21:0] C_LW  = 22'h0A;
  localparam logic [21:0] C_LD  = 22'h0E;
  localparam logic [21:0] C_SLW = 22'h0B;

  logic        clk, reset, in_valid, in_ready;
  logic [31:0] input_MA_PC, input_MA_ALU_Result, input_MA_op2, input_MA_IR;
  logic [21:0] input_MA_controlBus;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        out_valid, misalign;
  logic [31:0] output_MA_PC, output_MA_ALU_Result, output_MA_IR, MA_Ld_Result;
  logic [21:0] output_MA_controlBus;

  ma_stage_pipelined dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .input_MA_PC          (input_MA_PC),
    .input_MA_ALU_Result  (input_MA_ALU_Result),
    .input_MA_op2         (input_MA_op2),
    .input_MA_IR          (input_MA_IR),
    .input_MA_controlBus  (input_MA_controlBus),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_be               (mem_be),
    .mem_rdata            (mem_rdata),
    .mem_ready            (mem_ready),
    .out_valid            (out_valid),
    .output_MA_PC         (output_MA_PC),
    .output_MA_ALU_Result (output_MA_ALU_Result),
    .output_MA_IR         (output_MA_IR),
    .output_MA_controlBus (output_MA_controlBus),
    .MA_Ld_Result         (MA_Ld_Result),
    .misalign             (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] ctrl;
    logic [31:0] pc, alu, op2, rdata;
    int          delay;
    logic        mem, we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_ld;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc, alu, ir, ld;
    logic [21:0] ctrl;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[14];
  int   tests = 0, fails = 0, n_pushed = 0, n_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid) begin
      n_seen++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got pc 0x%0h, want no completion", output_MA_PC);
      end else begin
        e = sb_q.pop_front();
        check("out_pc", output_MA_PC, e.pc);
        check("out_alu", output_MA_ALU_Result, e.alu);
        check("out_ir", output_MA_IR, e.ir);
        check("out_ctrl", output_MA_controlBus, e.ctrl);
        check("ld_result", MA_Ld_Result, e.ld);
        check("misalign", misalign, e.mis);
      end
    end
  end

  // Called at posedge+1 with the stage idle; returns at posedge+1 with the stage idle again.
  task automatic issue(input vec_t v, input logic [31:0] ir);
    exp_t e;
    check("in_ready_idle", in_ready, 1'b1);
    in_valid            = 1'b1;
    input_MA_PC         = v.pc;
    input_MA_ALU_Result = v.alu;
    input_MA_op2        = v.op2;
    input_MA_IR         = ir;
    input_MA_controlBus = v.ctrl;
    if (!v.mem) begin
      mem_ready = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
    end
    e.pc = v.pc; e.alu = v.alu; e.ir = ir; e.ctrl = v.ctrl; e.ld = v.e_ld; e.mis = v.e_mis;
    sb_q.push_back(e);
    n_pushed++;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    check("mem_req", mem_req, v.mem);
    if (v.mem) begin
      check("mem_we", mem_we, v.we);
      check("mem_addr", mem_addr, v.e_addr);
      check("mem_be", mem_be, v.e_be);
      check("mem_wdata", mem_wdata, v.e_wdata);
      for (int d = 0; d < v.delay; d++) begin
        @(negedge clk);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_valid", out_valid, 1'b0);
        check("held_addr", mem_addr, v.e_addr);
        check("held_be", mem_be, v.e_be);
        @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      mem_rdata = v.rdata;
      @(negedge clk);
      check("access_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      check("done_out_valid", out_valid, 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want run to complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{C_ALU, 32'h100, 32'h55,       32'h0,         32'h0,         0, 1'b0, 1'b0, 32'h0,    4'h0, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{C_SB,  32'h104, 32'h1003,     32'hAABBCCDD,  32'h0,         3, 1'b1, 1'b1, 32'h1000, 4'h8, 32'hDDDDDDDD,  32'h0,         1'b0};
    vecs[2]  = '{C_LH,  32'h108, 32'h2002,     32'h0,         32'h80011234,  1, 1'b1, 1'b0, 32'h2000, 4'hC, 32'h0,         32'hFFFF8001,  1'b0};
    vecs[3]  = '{C_LHU, 32'h10C, 32'h2002,     32'h0,         32'h80011234,  0, 1'b1, 1'b0, 32'h2000, 4'hC, 32'h0,         32'h00008001,  1'b0};
    vecs[4]  = '{C_LW,  32'h110, 32'h3001,     32'h0,         32'h0,         0, 1'b0, 1'b0, 32'h0,    4'h0, 32'h0,         32'h0,         1'b1};
    vecs[5]  = '{C_LW,  32'h114, 32'h0,        32'h0,         32'h12345678,  0, 1'b1, 1'b0, 32'h0,    4'hF, 32'h0,         32'h12345678,  1'b0};
    vecs[6]  = '{C_ALU, 32'h118, 32'hDEADBEEF, 32'h0,         32'h0,         0, 1'b0, 1'b0, 32'h0,    4'h0, 32'h0,         32'h0,         1'b0};
    vecs[7]  = '{C_SH,  32'h11C, 32'h4002,     32'h1234ABCD,  32'h0,         2, 1'b1, 1'b1, 32'h4000, 4'hC, 32'hABCDABCD,  32'h0,         1'b0};
    vecs[8]  = '{C_LB,  32'h120, 32'h5001,     32'h0,         32'h11228033,  1, 1'b1, 1'b0, 32'h5000, 4'h2, 32'h0,         32'hFFFFFF80,  1'b0};
    vecs[9]  = '{C_LBU, 32'h124, 32'h5003,     32'h0,         32'h91228033,  0, 1'b1, 1'b0, 32'h5000, 4'h8, 32'h0,         32'h00000091,  1'b0};
    vecs[10] = '{C_LH,  32'h128, 32'h6001,     32'h0,         32'h0,         0, 1'b0, 1'b0, 32'h0,    4'h0, 32'h0,         32'h0,         1'b1};
    vecs[11] = '{C_LD,  32'h12C, 32'h7000,     32'h0,         32'h0,         0, 1'b0, 1'b0, 32'h0,    4'h0, 32'h0,         32'h0,         1'b1};
    vecs[12] = '{C_SLW, 32'h130, 32'h8004,     32'hCAFEF00D,  32'hFFFFFFFF,  1, 1'b1, 1'b1, 32'h8004, 4'hF, 32'hCAFEF00D,  32'h0,         1'b0};
    vecs[13] = '{C_SW,  32'h134, 32'h8002,     32'h0,         32'h0,         0, 1'b0, 1'b0, 32'h0,    4'h0, 32'h0,         32'h0,         1'b1};

    reset = 1'b1; in_valid = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    input_MA_PC = '0; input_MA_ALU_Result = '0; input_MA_op2 = '0;
    input_MA_IR = '0; input_MA_controlBus = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_ld_result", MA_Ld_Result, 32'h0);
    check("rst_out_pc", output_MA_PC, 32'h0);
    check("rst_misalign", misalign, 1'b0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Abandon an outstanding load by resetting while memory never answers.
    in_valid = 1'b1; input_MA_PC = 32'h200; input_MA_ALU_Result = 32'h10;
    input_MA_controlBus = C_LW;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_req_before", mem_req, 1'b1);
    check("abort_in_ready_before", in_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("abort_req_dropped", mem_req, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("post_abort_out_valid", out_valid, 1'b0);
    check("post_abort_in_ready", in_ready, 1'b1);
    check("post_abort_mem_req", mem_req, 1'b0);

    for (int i = 0; i < 14; i++) issue(vecs[i], 32'h13 | (32'(i) << 7));

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    check("pulse_count", n_seen, n_pushed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ma_stage_pipelined.md
Name: ma_stage_pipelined

Overview:
- Parametrised memory-access stage of the 5-stage pipeline. It sits between the EX/MA and MA/RW pipeline registers.
- Replaces the purely combinational MA pass-through with a registered stage that talks to data memory over a req/ready handshake. It stalls upstream while an access is outstanding.
- Supports byte, half and word (and dword when XLEN=64) loads and stores, with byte enables, sign/zero extension and misalignment detection.

Parameters:
- XLEN, 32, datapath/address width (32 or 64).
- CTRL_W, 22, control-bus width.
- ST_BIT, 0, control-bus bit flagging a store.
- LD_BIT, 1, control-bus bit flagging a load.
- SZ_LSB, 2, LSB of the 2-bit access-size field: 00 byte, 01 half, 10 word, 11 dword.
- UNS_BIT, 4, control-bus bit selecting zero-extension for loads.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  EX/MA holds a valid instruction
- in_ready  out  1  stage can accept; 0 = stall upstream
- input_MA_PC  in  XLEN  PC
- input_MA_ALU_Result  in  XLEN  effective address / ALU value
- input_MA_op2  in  XLEN  store data
- input_MA_IR  in  32  instruction
- input_MA_controlBus  in  CTRL_W  control bus
- mem_req  out  1  access request
- mem_we  out  1  1 = write
- mem_addr  out  XLEN  address, aligned to XLEN/8 bytes
- mem_wdata  out  XLEN  lane-replicated store data
- mem_be  out  XLEN/8  byte enables
- mem_rdata  in  XLEN  read data, valid with mem_ready
- mem_ready  in  1  access complete this cycle
- out_valid  out  1  MA/RW register valid (one-cycle pulse per instruction)
- output_MA_PC, output_MA_ALU_Result  out  XLEN  registered copies
- output_MA_IR  out  32  registered copy
- output_MA_controlBus  out  CTRL_W  registered copy
- MA_Ld_Result  out  XLEN  extended load data
- misalign  out  1  access was misaligned or illegal; qualified by out_valid

Behaviour:
- Reset (async): state IDLE. All outputs 0, except in_ready=1. mem_req drops immediately; an in-flight access is abandoned.
- FSM states: IDLE, ACCESS.
- IDLE:
  - in_ready=1. Accept when in_valid.
  - Non-memory instruction: copy fields to the output registers next edge with out_valid=1 (latency 1). MA_Ld_Result=0.
  - Load or store: latch fields into a holding register. Compute misalignment: half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0; dword when XLEN=32 is illegal.
  - Misaligned or illegal: no memory access. Next edge: out_valid=1, misalign=1, MA_Ld_Result=0.
  - Otherwise go to ACCESS.
- ACCESS:
  - in_ready=0.
  - mem_req=1, held stable with mem_we/addr/wdata/be until a cycle with mem_ready=1.
  - On that edge: load output registers, out_valid=1, return to IDLE. A new instruction can be accepted the following cycle.
  - Minimum memory-op latency is 2 cycles (accept, then ACCESS with mem_ready=1).
- Store formatting:
  - Byte: op2[7:0] replicated to every lane; be = one-hot at addr[LOG2(XLEN/8)-1:0].
  - Half: op2[15:0] replicated; be = 2'b11 shifted to the half-word lane.
  - Word/dword: be covers 4 or 8 bytes at the lane.
  - mem_addr = addr with its low LOG2(XLEN/8) bits cleared.
- Load formatting: select the lane from mem_rdata by the low address bits. Sign-extend to XLEN, or zero-extend if UNS_BIT=1.
- A control bus with both ST_BIT and LD_BIT set is treated as a store. The load result is 0.
- out_valid is deasserted in every cycle where no instruction completes. The other output registers hold their last value.
- mem_ready while mem_req=0 is ignored.

Decomposition:
- Shared package pipeline_pkg holds:
  - size-code constants SZ_B/SZ_H/SZ_W/SZ_D;
  - control-bus bit positions ST_BIT/LD_BIT/SZ_LSB/UNS_BIT;
  - FSM state enum.
- One combinational sub-module, ma_lane_align, does store replication, byte-enable generation, load extraction/extension and the misalign check. The FSM and registers stay in the top.

Test Plan:
- Reset asserted during ACCESS with mem_ready held 0 -> mem_req falls in the same cycle; after release in_ready=1 and out_valid=0.
- ALU op, PC=0x100, ALU_Result=0x55 -> one cycle later out_valid=1, output_MA_ALU_Result=0x55, mem_req never asserted.
- Store byte, addr=0x1003, op2=0xAABBCCDD -> mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xDDDDDDDD. mem_ready delayed 3 cycles -> in_ready=0 throughout, a single out_valid pulse.
- Load half signed, addr=0x2002, mem_rdata=0x8001_1234 -> MA_Ld_Result=0xFFFF8001. The same access with UNS_BIT=1 -> 0x00008001.
- Load word, addr=0x3001 -> no mem_req, out_valid=1 and misalign=1 one cycle after accept, MA_Ld_Result=0.
- Back-to-back load word (addr 0x0, mem_rdata=0x12345678, mem_ready same cycle) followed by an ALU op -> out_valid on consecutive-possible cycles with results 0x12345678 and then the ALU value, ordering preserved.
